// File: rtl/uart_pkg.sv
// Shared UART definitions for the transmit and receive paths on the clk_uart domain.
package uart_pkg;

    localparam int unsigned UART_OVERSAMPLE = 8;
    localparam int unsigned UART_DATA_BITS  = 8;

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } tx_state_t;

endpackage

// File: rtl/async_transmitter_if.sv
// Byte producer to transmitter valid/ready handshake.
interface async_transmitter_if;
    import uart_pkg::*;

    logic [UART_DATA_BITS-1:0] tx_data;
    logic                      tx_valid;
    logic                      tx_ready;

    modport master (output tx_data, output tx_valid, input tx_ready);
    modport slave  (input tx_data, input tx_valid, output tx_ready);

endinterface

// File: rtl/uart_tx_fifo.sv
// Synchronous first-word-fall-through byte FIFO with registered full/empty flags.
module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned WIDTH      = UART_DATA_BITS
) (
    input  logic             clk_uart,
    input  logic             rst_n,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty
);

    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam int unsigned PW = AW + 1;

    logic [WIDTH-1:0] mem [FIFO_DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [PW-1:0]    wr_ptr_nxt;
    logic [PW-1:0]    rd_ptr_nxt;
    logic             do_wr;
    logic             do_rd;

    // Pointer advance; the extra MSB separates full from empty when the indices match.
    always_comb begin
        do_wr      = wr_en && !full;
        do_rd      = rd_en && !empty;
        wr_ptr_nxt = do_wr ? wr_ptr + PW'(1) : wr_ptr;
        rd_ptr_nxt = do_rd ? rd_ptr + PW'(1) : rd_ptr;
    end

    always_ff @(posedge clk_uart or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            full   <= 1'b0;
            empty  <= 1'b1;
        end else begin
            wr_ptr <= wr_ptr_nxt;
            rd_ptr <= rd_ptr_nxt;
            empty  <= (wr_ptr_nxt == rd_ptr_nxt);
            full   <= (wr_ptr_nxt[AW] != rd_ptr_nxt[AW]) &&
                      (wr_ptr_nxt[AW-1:0] == rd_ptr_nxt[AW-1:0]);
        end
    end

    always_ff @(posedge clk_uart) begin
        if (do_wr) begin
            mem[wr_ptr[AW-1:0]] <= wr_data;
        end
    end

    assign rd_data = mem[rd_ptr[AW-1:0]];

endmodule

// File: rtl/async_transmitter.sv
// UART 8N1 transmitter: buffers bytes from a valid/ready port and shifts them out LSB-first.
module async_transmitter
    import uart_pkg::*;
#(
    parameter int unsigned OVERSAMPLE = UART_OVERSAMPLE,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic                clk_uart,
    input  logic                rst_n,
    async_transmitter_if.slave  host,
    output logic                tx,
    output logic                busy
);

    localparam int unsigned TICK_W = $clog2(OVERSAMPLE);
    localparam int unsigned BIT_W  = $clog2(UART_DATA_BITS);
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(OVERSAMPLE - 1);
    localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(UART_DATA_BITS - 1);

    tx_state_t                 state;
    tx_state_t                 state_nxt;
    logic [TICK_W-1:0]         tick;
    logic [TICK_W-1:0]         tick_nxt;
    logic [BIT_W-1:0]          bit_idx;
    logic [BIT_W-1:0]          bit_idx_nxt;
    logic [UART_DATA_BITS-1:0] shift_reg;
    logic [UART_DATA_BITS-1:0] shift_reg_nxt;
    logic                      tx_nxt;
    logic                      busy_nxt;
    logic                      tick_end;
    logic                      ready_en;
    logic                      fifo_wr;
    logic                      fifo_rd;
    logic                      fifo_full;
    logic                      fifo_empty;
    logic [UART_DATA_BITS-1:0] fifo_data;

    // ready_en keeps tx_ready low while rst_n is asserted.
    assign host.tx_ready = ready_en && !fifo_full;
    assign fifo_wr       = host.tx_valid && ready_en && !fifo_full;

    uart_tx_fifo #(
        .FIFO_DEPTH (FIFO_DEPTH),
        .WIDTH      (UART_DATA_BITS)
    ) u_fifo (
        .clk_uart (clk_uart),
        .rst_n    (rst_n),
        .wr_en    (fifo_wr),
        .wr_data  (host.tx_data),
        .rd_en    (fifo_rd),
        .rd_data  (fifo_data),
        .full     (fifo_full),
        .empty    (fifo_empty)
    );

    always_ff @(posedge clk_uart or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            tick      <= '0;
            bit_idx   <= '0;
            shift_reg <= '0;
            tx        <= 1'b1;
            busy      <= 1'b0;
            ready_en  <= 1'b0;
        end else begin
            state     <= state_nxt;
            tick      <= tick_nxt;
            bit_idx   <= bit_idx_nxt;
            shift_reg <= shift_reg_nxt;
            tx        <= tx_nxt;
            busy      <= busy_nxt;
            ready_en  <= 1'b1;
        end
    end

    // Next state; tx is derived from the current state so the line lags the FSM by one edge.
    always_comb begin
        state_nxt     = state;
        tick_nxt      = tick;
        bit_idx_nxt   = bit_idx;
        shift_reg_nxt = shift_reg;
        fifo_rd       = 1'b0;
        tx_nxt        = 1'b1;
        tick_end      = (tick == TICK_LAST);

        if (state != IDLE) begin
            tick_nxt = tick_end ? '0 : tick + TICK_W'(1);
        end

        case (state)
            IDLE: begin
                if (!fifo_empty) begin
                    fifo_rd       = 1'b1;
                    shift_reg_nxt = fifo_data;
                    state_nxt     = START;
                end
            end
            START: begin
                if (tick_end) begin
                    state_nxt   = DATA;
                    bit_idx_nxt = '0;
                end
            end
            DATA: begin
                if (tick_end) begin
                    if (bit_idx == BIT_LAST) begin
                        state_nxt = STOP;
                    end else begin
                        bit_idx_nxt = bit_idx + BIT_W'(1);
                    end
                end
            end
            STOP: begin
                // Chaining straight into START keeps the frame period at 10 bits.
                if (tick_end) begin
                    if (!fifo_empty) begin
                        fifo_rd       = 1'b1;
                        shift_reg_nxt = fifo_data;
                        state_nxt     = START;
                    end else begin
                        state_nxt = IDLE;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase

        case (state)
            START:   tx_nxt = 1'b0;
            DATA:    tx_nxt = shift_reg[bit_idx];
            default: tx_nxt = 1'b1;
        endcase

        busy_nxt = (state != IDLE) || !fifo_empty;
    end

endmodule
